// File: rtl/rvcpu_pkg.sv
// rvcpu_pkg: shared types for the CPU pipeline.
//   br_type_e   - conditional-branch comparison select (funct3 encoding)
//   exb_ctrl_t  - control bundle carried unchanged from IDR through EXB to EXA
package rvcpu_pkg;

  // Codes 2 and 3 are unused; the comparator reports "not taken" for them.
  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd4,
    BGE  = 3'd5,
    BLTU = 3'd6,
    BGEU = 3'd7
  } br_type_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       rf_wr_en;
    logic [1:0] rf_wr_sel;
    logic [3:0] alu_ctrl;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [2:0] dm_rd_ctrl;
    logic [1:0] dm_wr_ctrl;
    logic       m_sel;
  } exb_ctrl_t;

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational comparator for conditional branches.
// Ports:
//   rs1, rs2 - XLEN-bit operands
//   br_type  - comparison select (rvcpu_pkg::br_type_e encoding)
//   cond     - 1 when the branch condition holds
module branch_cmp
  import rvcpu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      br_type,
  output logic            cond
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BEQ:     cond = eq;
      BNE:     cond = ~eq;
      BLT:     cond = lt_s;
      BGE:     cond = ~lt_s;
      BLTU:    cond = lt_u;
      BGEU:    cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_exb_stage_p.sv
// pipeline_exb_stage_p: branch-resolution stage between IDR and EXA.
// Resolves branches/JAL/JALR against the fetch prediction, raises a
// single-cycle redirect on mispredict, strobes a predictor update, and
// registers the uop towards EXA behind a valid/ready handshake.
// Ports:
//   clk, reset (async, active-low), flush_i
//   in_valid_i/in_ready_o, pc_i, rs1_i, rs2_i, imm_i, ctrl_i  - IDR side
//   is_branch_i, is_jal_i, is_jalr_i, br_type_i               - instruction class
//   pred_taken_i, pred_target_i                               - fetch prediction
//   redirect_o, redirect_pc_o                                 - refetch request
//   bp_upd_valid_o, bp_upd_taken_o, bp_upd_target_o          - predictor update
//   out_valid_o/out_ready_i, pc_o, rs1_o, rs2_o, imm_o, ctrl_o, misalign_o - EXA side
//   branch_cnt_o, mispred_cnt_o - saturating counters, only when
//                                 EXB_PERF_CNT_EN is defined
module pipeline_exb_stage_p
  import rvcpu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int CTRL_W = $bits(rvcpu_pkg::exb_ctrl_t)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              is_branch_i,
  input  logic              is_jal_i,
  input  logic              is_jalr_i,
  input  logic [2:0]        br_type_i,
  input  logic              pred_taken_i,
  input  logic [XLEN-1:0]   pred_target_i,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              bp_upd_valid_o,
  output logic              bp_upd_taken_o,
  output logic [XLEN-1:0]   bp_upd_target_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   rs1_o,
  output logic [XLEN-1:0]   rs2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              misalign_o
`ifdef EXB_PERF_CNT_EN
  ,
  output logic [31:0]       branch_cnt_o,
  output logic [31:0]       mispred_cnt_o
`endif
);

  logic            cond;
  logic            taken;
  logic            fire;
  logic            mispredict;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fallthrough;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1     (rs1_i),
    .rs2     (rs2_i),
    .br_type (br_type_i),
    .cond    (cond)
  );

  assign in_ready_o = ~out_valid_o | out_ready_i;
  assign fire       = in_valid_i & in_ready_o & ~flush_i;

  assign taken       = is_jal_i | is_jalr_i | (is_branch_i & cond);
  assign base        = is_jalr_i ? rs1_i : pc_i;
  assign sum         = base + imm_i;
  // JALR clears bit 0 of the computed address.
  assign target      = is_jalr_i ? {sum[XLEN-1:1], 1'b0} : sum;
  assign fallthrough = pc_i + XLEN'(4);

  assign mispredict = (taken != pred_taken_i) | (taken & (pred_target_i != target));

  // Resolution only counts on fire, so a stalled uop reports exactly once.
  assign redirect_o      = fire & mispredict;
  assign redirect_pc_o   = taken ? target : fallthrough;
  assign bp_upd_valid_o  = fire & (is_branch_i | is_jal_i | is_jalr_i);
  assign bp_upd_taken_o  = taken;
  assign bp_upd_target_o = target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_o <= 1'b0;
      misalign_o  <= 1'b0;
      pc_o        <= '0;
      rs1_o       <= '0;
      rs2_o       <= '0;
      imm_o       <= '0;
      ctrl_o      <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      misalign_o  <= 1'b0;
    end else if (fire) begin
      out_valid_o <= 1'b1;
      misalign_o  <= taken & (target[1:0] != 2'b00);
      pc_o        <= pc_i;
      rs1_o       <= rs1_i;
      rs2_o       <= rs2_i;
      imm_o       <= imm_i;
      ctrl_o      <= ctrl_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef EXB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (bp_upd_valid_o && (branch_cnt_o != 32'hFFFF_FFFF))
        branch_cnt_o <= branch_cnt_o + 32'd1;
      if (redirect_o && (mispred_cnt_o != 32'hFFFF_FFFF))
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_exb_stage_p.sv
// tb_pipeline_exb_stage_p: directed, table-driven bench for the EXB stage.
// Exercises a 64-bit instance with a vector table plus stall, flush and
// reset sequences, and a 32-bit instance for address wrap. Counter checks
// are included when EXB_PERF_CNT_EN is defined.
module tb_pipeline_exb_stage_p;
  import rvcpu_pkg::*;

  localparam int CW = $bits(exb_ctrl_t);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [63:0]   pc_i = '0, rs1_i = '0, rs2_i = '0, imm_i = '0;
  logic [CW-1:0] ctrl_i = '0;
  logic          is_branch_i = 1'b0, is_jal_i = 1'b0, is_jalr_i = 1'b0;
  logic [2:0]    br_type_i = 3'd0;
  logic          pred_taken_i = 1'b0;
  logic [63:0]   pred_target_i = '0;
  logic          redirect_o;
  logic [63:0]   redirect_pc_o;
  logic          bp_upd_valid_o, bp_upd_taken_o;
  logic [63:0]   bp_upd_target_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [63:0]   pc_o, rs1_o, rs2_o, imm_o;
  logic [CW-1:0] ctrl_o;
  logic          misalign_o;

  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [31:0]   s_pc = '0, s_rs1 = '0, s_rs2 = '0, s_imm = '0;
  logic          s_isb = 1'b0, s_jal = 1'b0;
  logic          s_pred = 1'b0;
  logic [31:0]   s_pt = '0;
  logic          s_red;
  logic [31:0]   s_rpc;
  logic          s_updv, s_updt;
  logic [31:0]   s_updtg;
  logic          s_ov;
  logic [31:0]   s_pco, s_rs1o, s_rs2o, s_immo;
  logic [CW-1:0] s_ctrlo;
  logic          s_mis;

`ifdef EXB_PERF_CNT_EN
  logic [31:0]   branch_cnt_o, mispred_cnt_o;
  logic [31:0]   s_bcnt, s_mcnt;
`endif

  always #5 clk = ~clk;

  pipeline_exb_stage_p #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .ctrl_i(ctrl_i),
    .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
    .br_type_i(br_type_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .bp_upd_valid_o(bp_upd_valid_o), .bp_upd_taken_o(bp_upd_taken_o),
    .bp_upd_target_o(bp_upd_target_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .ctrl_o(ctrl_o),
    .misalign_o(misalign_o)
`ifdef EXB_PERF_CNT_EN
    , .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
`endif
  );

  pipeline_exb_stage_p #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush_i(1'b0),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .pc_i(s_pc), .rs1_i(s_rs1), .rs2_i(s_rs2), .imm_i(s_imm), .ctrl_i('0),
    .is_branch_i(s_isb), .is_jal_i(s_jal), .is_jalr_i(1'b0),
    .br_type_i(3'd0), .pred_taken_i(s_pred), .pred_target_i(s_pt),
    .redirect_o(s_red), .redirect_pc_o(s_rpc),
    .bp_upd_valid_o(s_updv), .bp_upd_taken_o(s_updt),
    .bp_upd_target_o(s_updtg),
    .out_valid_o(s_ov), .out_ready_i(1'b1),
    .pc_o(s_pco), .rs1_o(s_rs1o), .rs2_o(s_rs2o), .imm_o(s_immo), .ctrl_o(s_ctrlo),
    .misalign_o(s_mis)
`ifdef EXB_PERF_CNT_EN
    , .branch_cnt_o(s_bcnt), .mispred_cnt_o(s_mcnt)
`endif
  );

  typedef struct {
    logic [63:0] pc, rs1, rs2, imm;
    logic        isb, jal, jalr;
    logic [2:0]  bt;
    logic        pred;
    logic [63:0] pt;
    logic        exp_red;
    logic [63:0] exp_rpc;
    logic        exp_upd, exp_tk;
    logic [63:0] exp_tgt;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_bcnt = 0;
  int   exp_mcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [63:0] pc, rs1, rs2, imm, input logic isb, jal, jalr,
                     input logic [2:0] bt, input logic pred, input logic [63:0] pt,
                     input logic er, input logic [63:0] erpc, input logic eu, etk,
                     input logic [63:0] etg, input logic em);
    vec_t v;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.isb = isb; v.jal = jal; v.jalr = jalr; v.bt = bt;
    v.pred = pred; v.pt = pt;
    v.exp_red = er; v.exp_rpc = erpc; v.exp_upd = eu; v.exp_tk = etk;
    v.exp_tgt = etg; v.exp_mis = em;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v, input logic [CW-1:0] c);
    pc_i = v.pc; rs1_i = v.rs1; rs2_i = v.rs2; imm_i = v.imm;
    is_branch_i = v.isb; is_jal_i = v.jal; is_jalr_i = v.jalr;
    br_type_i = v.bt; pred_taken_i = v.pred; pred_target_i = v.pt;
    ctrl_i = c;
    in_valid_i = 1'b1;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    vec_t v;
    //   pc       rs1      rs2      imm                   b  jal jalr bt    pred pt          red rpc        upd tk tgt        mis
    add(64'h100, 64'd5,   64'd5,   64'h20,               1, 0, 0, 3'd0, 0, 64'h0,     1, 64'h120, 1, 1, 64'h120, 0); // BEQ taken
    add(64'h20,  64'd1,   ONES,    64'h20,               1, 0, 0, 3'd6, 1, 64'h40,    0, 64'h40,  1, 1, 64'h40,  0); // BLTU
    add(64'h200, 64'h1003,64'd0,   64'h0,                0, 0, 1, 3'd0, 0, 64'h0,     1, 64'h1002,1, 1, 64'h1002,1); // JALR
    add(64'h300, 64'd7,   64'd7,   64'h10,               1, 0, 0, 3'd1, 0, 64'h0,     0, 64'h304, 1, 0, 64'h310, 0); // BNE nt
    add(64'h400, ONES,    64'd1,   64'hFFFF_FFFF_FFFF_FFF8,1,0,0, 3'd4, 1, 64'h3F8,   0, 64'h3F8, 1, 1, 64'h3F8, 0); // BLT signed
    add(64'h500, ONES,    64'd1,   64'h40,               1, 0, 0, 3'd5, 1, 64'h540,   1, 64'h504, 1, 0, 64'h540, 0); // BGE nt
    add(64'h600, ONES,    64'd1,   64'h8,                1, 0, 0, 3'd7, 1, 64'h700,   1, 64'h608, 1, 1, 64'h608, 0); // BGEU bad target
    add(64'h700, 64'd3,   64'd3,   64'h10,               1, 0, 0, 3'd2, 0, 64'h0,     0, 64'h704, 1, 0, 64'h710, 0); // code 2
    add(64'h800, 64'd0,   64'd0,   64'h6,                0, 1, 0, 3'd0, 1, 64'h806,   0, 64'h806, 1, 1, 64'h806, 1); // JAL misaligned
    add(64'h900, 64'd0,   64'd0,   64'h4,                0, 0, 0, 3'd0, 0, 64'h0,     0, 64'h904, 0, 0, 64'h904, 0); // non-branch
    add(64'hA00, ONES,    64'd1,   64'h4,                1, 0, 0, 3'd6, 0, 64'h0,     0, 64'hA04, 1, 0, 64'hA04, 0); // BLTU nt

    #12;
    chk("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("reset_pc_o", pc_o, 64'd0);
    chk("reset_misalign", {63'd0, misalign_o}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", {63'd0, in_ready_o}, 64'd1);
    chk("reset_redirect", {63'd0, redirect_o}, 64'd0);
`ifdef EXB_PERF_CNT_EN
    chk("reset_branch_cnt", {32'd0, branch_cnt_o}, 64'd0);
`endif

    // back-to-back vectors at full throughput
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v, CW'(i + 1));
      @(negedge clk);
      chk($sformatf("v%0d_redirect", i), {63'd0, redirect_o}, {63'd0, v.exp_red});
      chk($sformatf("v%0d_redirect_pc", i), redirect_pc_o, v.exp_rpc);
      chk($sformatf("v%0d_upd_valid", i), {63'd0, bp_upd_valid_o}, {63'd0, v.exp_upd});
      chk($sformatf("v%0d_upd_taken", i), {63'd0, bp_upd_taken_o}, {63'd0, v.exp_tk});
      chk($sformatf("v%0d_upd_target", i), bp_upd_target_o, v.exp_tgt);
      exp_bcnt += int'(v.exp_upd);
      exp_mcnt += int'(v.exp_red);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid_o}, 64'd1);
      chk($sformatf("v%0d_pc_o", i), pc_o, v.pc);
      chk($sformatf("v%0d_rs1_o", i), rs1_o, v.rs1);
      chk($sformatf("v%0d_ctrl_o", i), {{(64-CW){1'b0}}, ctrl_o}, 64'(i + 1));
      chk($sformatf("v%0d_misalign", i), {63'd0, misalign_o}, {63'd0, v.exp_mis});
    end

    // drain, then park a filler uop in the output register with EXA stalled
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("drain_out_valid", {63'd0, out_valid_o}, 64'd0);
    v = vecs[9];
    v.pc = 64'hB00;
    drive(v, '0);
    out_ready_i = 1'b0;
    @(posedge clk); #1;
    chk("stall_fill_valid", {63'd0, out_valid_o}, 64'd1);
    // mispredicted BEQ held at the input for 3 stalled cycles
    v = vecs[0];
    v.pc = 64'hC00;
    drive(v, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", k), {63'd0, in_ready_o}, 64'd0);
      chk($sformatf("stall%0d_redirect", k), {63'd0, redirect_o}, 64'd0);
      chk($sformatf("stall%0d_upd_valid", k), {63'd0, bp_upd_valid_o}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_pc_o", k), pc_o, 64'hB00);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("accept_redirect", {63'd0, redirect_o}, 64'd1);
    chk("accept_redirect_pc", redirect_pc_o, 64'hC20);
    exp_bcnt++;
    exp_mcnt++;
    @(posedge clk); #1;
    chk("accept_pc_o", pc_o, 64'hC00);
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("post_accept_redirect", {63'd0, redirect_o}, 64'd0);

    // flush against a mispredicting, misaligned JAL
    @(posedge clk); #1;
    v = vecs[8];
    v.pred = 1'b0;
    drive(v, '0);
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_redirect", {63'd0, redirect_o}, 64'd0);
    chk("flush_upd_valid", {63'd0, bp_upd_valid_o}, 64'd0);
    @(posedge clk); #1;
    chk("flush_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("flush_misalign", {63'd0, misalign_o}, 64'd0);
    flush_i = 1'b0;
    in_valid_i = 1'b0;

    // 32-bit instance: address wrap
    s_pc = 32'hFFFF_FFFC; s_rs1 = 32'd1; s_rs2 = 32'd2; s_imm = 32'h10;
    s_isb = 1'b1; s_pred = 1'b1; s_pt = 32'h0000_000C; s_in_valid = 1'b1;
    @(negedge clk);
    chk("x32_nt_redirect_pc", {32'd0, s_rpc}, 64'd0);
    chk("x32_nt_redirect", {63'd0, s_red}, 64'd1);
    @(posedge clk); #1;
    s_isb = 1'b0; s_jal = 1'b1; s_imm = 32'h8; s_pred = 1'b1; s_pt = 32'h4;
    @(negedge clk);
    chk("x32_jal_target", {32'd0, s_updtg}, 64'd4);
    chk("x32_jal_redirect", {63'd0, s_red}, 64'd0);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_jal = 1'b0;

`ifdef EXB_PERF_CNT_EN
    chk("branch_cnt", {32'd0, branch_cnt_o}, 64'(exp_bcnt));
    chk("mispred_cnt", {32'd0, mispred_cnt_o}, 64'(exp_mcnt));
    chk("x32_branch_cnt", {32'd0, s_bcnt}, 64'd2);
    chk("x32_mispred_cnt", {32'd0, s_mcnt}, 64'd1);
`endif

    // reset in the middle of traffic
    v = vecs[2];
    drive(v, CW'(5));
    @(posedge clk); #1;
    chk("pre_reset_valid", {63'd0, out_valid_o}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("midreset_pc_o", pc_o, 64'd0);
    chk("midreset_rs1_o", rs1_o, 64'd0);
    chk("midreset_ctrl_o", {{(64-CW){1'b0}}, ctrl_o}, 64'd0);
    chk("midreset_misalign", {63'd0, misalign_o}, 64'd0);
`ifdef EXB_PERF_CNT_EN
    chk("midreset_branch_cnt", {32'd0, branch_cnt_o}, 64'd0);
    chk("midreset_mispred_cnt", {32'd0, mispred_cnt_o}, 64'd0);
`endif
    in_valid_i = 1'b0;
    @(posedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
